// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: chooses the next program counter value each cycle and decides
// when the PC register loads it. Inputs are the hazard unit, ID jump decode,
// EX branch resolution, traps and the instruction-memory ready handshake.
// It also drives the IF/ID and ID/EX squash signals and saves the trap return PC.
//
// state | meaning
// BOOT  | after reset: load RESET_VECTOR once, then wait BOOT_CYCLES cycles in total
// RUN   | normal fetch: sequential PC, or a redirect taken in the same cycle
// REDIR | a redirect arrived while a fetch was in flight; hold it until imem_ready
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic [1:0]  state
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
  localparam logic [31:0]   ALIGN     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] boot_cnt, boot_cnt_d;
  logic [31:0]   redir_tgt, redir_tgt_d;
  logic [31:0]   epc_d;
  logic [31:0]   sel_tgt;
  logic          redirect;
  logic          full_flush;

  assign state = state_q;

  // Select the RUN-state redirect target by priority trap > branch > unstalled jump.
  always_comb begin
    sel_tgt    = (pc + 32'd4) & ALIGN;
    redirect   = 1'b0;
    full_flush = 1'b0;
    if (trap) begin
      sel_tgt    = TRAP_VECTOR & ALIGN;
      redirect   = 1'b1;
      full_flush = 1'b1;
    end else if (branch_taken) begin
      sel_tgt    = branch_target & ALIGN;
      redirect   = 1'b1;
      full_flush = 1'b1;
    end else if (jump && !stall) begin
      sel_tgt    = jump_target & ALIGN;
      redirect   = 1'b1;
    end
  end

  // Zero-latency outputs and next-state values from the current state and inputs.
  always_comb begin
    npc         = RESET_VECTOR & ALIGN;
    pc_we       = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fetch_valid = 1'b0;
    state_d     = state_q;
    boot_cnt_d  = boot_cnt;
    redir_tgt_d = redir_tgt;
    epc_d       = epc;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          npc = sel_tgt;
          if (trap) epc_d = trap_pc;
          if (redirect) begin
            pc_we       = imem_ready;
            if_id_flush = 1'b1;
            id_ex_flush = full_flush;
            if (!imem_ready) begin
              redir_tgt_d = sel_tgt;
              state_d     = REDIR;
            end
          end else begin
            pc_we       = imem_ready & ~stall;
            fetch_valid = imem_ready & ~stall;
          end
        end
        REDIR: begin
          // The in-flight fetch is being discarded, so only traps and imem_ready matter here.
          npc   = trap ? (TRAP_VECTOR & ALIGN) : redir_tgt;
          pc_we = imem_ready;
          if (trap) begin
            epc_d       = trap_pc;
            redir_tgt_d = TRAP_VECTOR & ALIGN;
            id_ex_flush = 1'b1;
          end
          if_id_flush = imem_ready | trap;
          if (imem_ready) state_d = RUN;
        end
        default: begin
          // BOOT, and recovery from the unused encoding.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (state_q != BOOT) begin
            state_d    = BOOT;
            boot_cnt_d = '0;
          end else begin
            pc_we      = (boot_cnt == '0);
            boot_cnt_d = boot_cnt + CW'(1);
            if (boot_cnt == BOOT_LAST) state_d = RUN;
          end
        end
      endcase
    end
  end

  // State, boot counter, pending redirect target and EPC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      boot_cnt  <= '0;
      redir_tgt <= '0;
      epc       <= '0;
    end else begin
      state_q   <= state_d;
      boot_cnt  <= boot_cnt_d;
      redir_tgt <= redir_tgt_d;
      epc       <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of the fetch sequencing rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;
  localparam int          BC = 2;

  logic        clk = 1'b0;
  logic        rst, imem_ready, stall, jump, branch_taken, trap;
  logic [31:0] pc, jump_target, branch_target, trap_pc;
  logic [31:0] npc, epc;
  logic        pc_we, if_id_flush, id_ex_flush, fetch_valid;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_ready(imem_ready), .stall(stall),
    .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .trap(trap), .trap_pc(trap_pc),
    .npc(npc), .pc_we(pc_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fetch_valid(fetch_valid), .epc(epc), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = boot, 1 = running, 2 = waiting to apply a redirect.
  int          m_mode;
  int          m_boot_seen;
  logic [31:0] m_epc, m_pending;
  logic [31:0] e_npc;
  logic        e_we, e_fi, e_fe, e_fv, e_redir;
  logic [31:0] obs_npc;
  logic        obs_we;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_outputs();
    e_npc = al(RV); e_we = 0; e_fi = 0; e_fe = 0; e_fv = 0; e_redir = 0;
    if (rst) begin
      e_fi = 1; e_fe = 1;
    end else if (m_mode == 0) begin
      e_fi = 1; e_fe = 1;
      e_we = (m_boot_seen == 0);
    end else if (m_mode == 1) begin
      if (trap)                  begin e_npc = al(TV);            e_fi = 1; e_fe = 1; e_redir = 1; end
      else if (branch_taken)     begin e_npc = al(branch_target); e_fi = 1; e_fe = 1; e_redir = 1; end
      else if (jump && !stall)   begin e_npc = al(jump_target);   e_fi = 1;           e_redir = 1; end
      else begin
        e_npc = al(pc + 32'd4);
        e_we  = imem_ready && !stall;
        e_fv  = e_we;
      end
      if (e_redir) e_we = imem_ready;
    end else begin
      e_npc = trap ? al(TV) : m_pending;
      e_we  = imem_ready;
      e_fi  = imem_ready || trap;
      e_fe  = trap;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      m_mode = 0; m_boot_seen = 0; m_epc = 0; m_pending = 0;
    end else if (m_mode == 0) begin
      m_boot_seen++;
      if (m_boot_seen == BC) m_mode = 1;
    end else if (m_mode == 1) begin
      if (trap) m_epc = trap_pc;
      if (e_redir && !imem_ready) begin
        m_pending = e_npc;
        m_mode    = 2;
      end
    end else begin
      if (trap) begin m_epc = trap_pc; m_pending = al(TV); end
      if (imem_ready) m_mode = 1;
    end
  endtask

  // Entered at posedge+1 with inputs driven; compares at the falling edge, then clocks.
  task automatic run_cycle();
    #4;
    model_outputs();
    check("pc_we", {31'd0, pc_we}, {31'd0, e_we});
    check("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_fi});
    check("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_fe});
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
    if (rst || e_we || m_mode == 1) check("npc", npc, e_npc);
    check("npc_align", {30'd0, npc[1:0]}, 32'd0);
    check("state", {30'd0, state}, 32'(m_mode));
    check("epc", epc, m_epc);
    obs_npc = npc;
    obs_we  = pc_we;
    @(posedge clk);
    model_clock();
    #1;
    if (e_we) pc = e_npc;
  endtask

  task automatic drive(input bit r, input bit rdy, input bit st, input bit j,
                       input logic [31:0] jt, input bit b, input logic [31:0] bt,
                       input bit t, input logic [31:0] tp);
    rst = r; imem_ready = rdy; stall = st; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt; trap = t; trap_pc = tp;
    run_cycle();
  endtask

  initial begin
    rst = 1; imem_ready = 0; stall = 0; jump = 0; branch_taken = 0; trap = 0;
    pc = 0; jump_target = 0; branch_target = 0; trap_pc = 0;
    @(posedge clk);
    m_mode = 0; m_boot_seen = 0; m_epc = 0; m_pending = 0;
    #1;

    // Reset and boot sequence
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_npc", obs_npc, RV);
    drive(0, 1, 1, 1, 32'h44, 1, 32'h88, 1, 32'h99);
    check("boot_first_we", {31'd0, obs_we}, 32'd1);
    check("boot_first_npc", obs_npc, RV);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("boot_second_we", {31'd0, obs_we}, 32'd0);
    check("boot_to_run", {30'd0, state}, 32'd1);

    // Sequential fetch and wrap
    pc = 32'h100;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("seq_npc", obs_npc, 32'h104);
    pc = 32'hFFFF_FFFC;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_npc", obs_npc, 32'h0);

    // Stall masks jump; branch overrides stall
    drive(0, 1, 1, 1, 32'h400, 0, 0, 0, 0);
    check("stall_jump_we", {31'd0, obs_we}, 32'd0);
    drive(0, 1, 1, 0, 0, 1, 32'h200, 0, 0);
    check("branch_over_stall", obs_npc, 32'h200);

    // Priorities
    drive(0, 1, 0, 1, 32'h500, 1, 32'h240, 0, 0);
    check("branch_over_jump", obs_npc, 32'h240);
    drive(0, 1, 0, 1, 32'h500, 1, 32'h240, 1, 32'h1234);
    check("trap_npc", obs_npc, TV);
    check("trap_epc", epc, 32'h1234);

    // Redirect while the fetch is in flight
    drive(0, 0, 0, 0, 0, 1, 32'h300, 0, 0);
    check("redir_hold_we", {31'd0, obs_we}, 32'd0);
    check("redir_state", {30'd0, state}, 32'd2);
    drive(0, 0, 1, 1, 32'h600, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h700, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("redir_apply_npc", obs_npc, 32'h300);
    check("redir_back_run", {30'd0, state}, 32'd1);

    // Trap during REDIR, then rst during REDIR
    drive(0, 0, 0, 0, 0, 1, 32'h300, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h2C);
    check("redir_trap_epc", epc, 32'h2C);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("redir_trap_npc", obs_npc, TV);
    drive(0, 0, 0, 0, 0, 1, 32'h340, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_in_redir", {30'd0, state}, 32'd0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_drops_redirect", {30'd0, state}, 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) pc = $urandom;
      else if ($urandom_range(0, 11) == 0) pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 6) == 0, $urandom,
            $urandom_range(0, 14) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
